instr_fetch_stage: RTL
======================

// Module: instr_fetch_stage
// PURPOSE
// - Upstream neighbour of the MIPS control unit: owns the PC and fetches 32-bit words over a req/ack memory port.
// - Holds the fetched word in an instruction register (IR) and splits it into OP/Funct/rs/rt/rd/imm for decode.
// - Computes next PC from the Jump and taken-branch signals returned for the instruction currently in IR.
// - Sequences one instruction at a time: FETCH -> EXEC -> FETCH, stallable.
// PARAMETERS
// - RESET_PC   32'h0000_0000  PC value loaded on reset
// - MAX_WAIT   15             FETCH cycles without imem_ack before fetch_err is raised (>=1)
// PORTS
// - clk           in   1   single clock, all state on rising edge
// - rst           in   1   reset, synchronous, active-high
// - stall         in   1   hold current instruction in EXEC (no PC update)
// - jump          in   1   Jump from control for the IR instruction (valid in EXEC)
// - branch_taken  in   1   Branch AND ULA zero for the IR instruction (valid in EXEC)
// - imem_req      out  1   memory request, held until ack
// - imem_addr     out  32  word address = pc, stable while imem_req=1
// - imem_ack      in   1   memory response valid, single-cycle pulse
// - imem_rdata    in   32  instruction word, sampled when imem_ack=1 in FETCH
// - instr_valid   out  1   IR holds a live instruction (state EXEC)
// - op            out  6   IR[31:26]
// - funct         out  6   IR[5:0]
// - rs, rt, rd    out  5   IR[25:21], IR[20:16], IR[15:11]
// - imm           out  16  IR[15:0]
// - pc            out  32  address of the instruction in IR
// - pc_plus4      out  32  pc + 4
// - fetch_err     out  1   sticky: a fetch exceeded MAX_WAIT cycles
// BEHAVIOUR
// - States: S_RESET, S_FETCH, S_EXEC. Reset forces S_RESET; next cycle always S_FETCH.
// - Reset values: pc=RESET_PC, IR=32'h0 (NOP), instr_valid=0, imem_req=0, fetch_err=0, wait_cnt=0.
// - S_FETCH: imem_req=1, imem_addr=pc. On imem_ack: IR<=imem_rdata, wait_cnt<=0, go S_EXEC.
//   Ack in the same cycle req first rises is accepted (min fetch = 1 cycle).
// - Without ack, wait_cnt increments (saturating). When wait_cnt reaches MAX_WAIT, fetch_err<=1.
//   fetch_err is cleared only by rst; the fetch keeps waiting after the error is raised.
// - S_EXEC: instr_valid=1, imem_req=0.
//   - If stall=1: stay in EXEC; pc and IR are unchanged.
//   - If stall=0: pc<=next_pc, go S_FETCH.
//   - jump and branch_taken are sampled only in S_EXEC with stall=0.
// - next_pc priority, evaluated on current IR/pc:
//   1. jump=1 -> {pc_plus4[31:28], IR[25:0], 2'b00}
//   2. branch_taken=1 -> pc_plus4 + {{14{IR[15]}}, IR[15:0], 2'b00}
//   3. otherwise -> pc_plus4
//   - jump and branch_taken both 1: jump wins.
// - Arithmetic is modulo 2^32; pc=32'hFFFF_FFFC with no jump/branch wraps to 32'h0.
// - Throughput is one instruction per (fetch cycles + 1); minimum 2 cycles/instruction.
// - imem_ack outside S_FETCH is ignored; no IR or state change.
// - rst asserted mid-fetch abandons the request: imem_req=0 the next cycle and any ack in the rst cycle is dropped.
// - Field outputs (op..imm) are combinational from IR; they hold their last value while instr_valid=0.
// STRUCTURE
// - Shared package mips_pkg:
//   - fetch_state_t enum {S_RESET, S_FETCH, S_EXEC}
//   - OP_RTYPE/OP_ADDI/OP_LW/OP_SW/OP_BEQ/OP_J opcode constants
//   - INSTR_W=32
// - Sub-module pc_next_calc (combinational: pc, IR, jump, branch_taken -> pc_plus4, next_pc).
// - FSM, wait counter, PC and IR registers live in this module.
// TESTING
// - Reset, then ack one cycle after each req with words 0x20080005, 0x20090003 -> imem_addr 0x0 then 0x4; op=0x08, imm=0x0005 then 0x0003.
// - EXEC with IR=0x1000FFFF, pc=0x10, branch_taken=1 -> next imem_addr=0x10 (0x14 + (-4)).
// - EXEC with IR=0x08000040, jump=1 and branch_taken=1 both set -> next imem_addr=0x100 (jump wins).
// - stall=1 for 3 cycles in EXEC -> instr_valid stays 1; pc and op stay constant; imem_req=0; PC advances on the first cycle stall=0.
// - Withhold ack MAX_WAIT cycles -> fetch_err=1 and stays set; later ack completes the fetch; only rst clears fetch_err.
// - pc=0xFFFFFFFC with no branch/jump -> next imem_addr=0x0. rst during a pending fetch with a simultaneous ack -> IR=0, pc=RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end types: fetch FSM states, opcode constants, instruction width.
package mips_pkg;

   localparam int INSTR_W = 32;

   typedef enum logic [1:0] {
      S_RESET,
      S_FETCH,
      S_EXEC
   } fetch_state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // Sign-extended, word-scaled branch displacement.
   function automatic logic [INSTR_W-1:0] br_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: jump beats taken branch, otherwise sequential.
module pc_next_calc
   import mips_pkg::*;
(
   input  logic [INSTR_W-1:0] pc,
   input  logic [25:0]        ir_low,
   input  logic               jump,
   input  logic               branch_taken,
   output logic [INSTR_W-1:0] pc_plus4,
   output logic [INSTR_W-1:0] next_pc
);

   always_comb begin
      pc_plus4 = pc + 32'd4;
      if (jump)
         next_pc = {pc_plus4[31:28], ir_low, 2'b00};
      else if (branch_taken)
         next_pc = pc_plus4 + br_offset(ir_low[15:0]);
      else
         next_pc = pc_plus4;
   end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: owns PC and IR, fetches over req/ack, one instruction in flight.
module instr_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                 MAX_WAIT = 15
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               jump,
   input  logic               branch_taken,
   output logic               imem_req,
   output logic [INSTR_W-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [5:0]         op,
   output logic [5:0]         funct,
   output logic [4:0]         rs,
   output logic [4:0]         rt,
   output logic [4:0]         rd,
   output logic [15:0]        imm,
   output logic [INSTR_W-1:0] pc,
   output logic [INSTR_W-1:0] pc_plus4,
   output logic               fetch_err
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   fetch_state_t       state, state_nxt;
   logic [INSTR_W-1:0] ir;
   logic [INSTR_W-1:0] next_pc;
   logic [WCW-1:0]     wait_cnt;

   pc_next_calc u_pc_next (
      .pc           (pc),
      .ir_low       (ir[25:0]),
      .jump         (jump),
      .branch_taken (branch_taken),
      .pc_plus4     (pc_plus4),
      .next_pc      (next_pc)
   );

   always_comb begin
      state_nxt   = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state)
         S_RESET: state_nxt = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) state_nxt = S_EXEC;
         end
         S_EXEC: begin
            instr_valid = 1'b1;
            if (!stall) state_nxt = S_FETCH;
         end
         default: state_nxt = S_RESET;
      endcase
   end

   // fetch_err rises on the edge that completes the MAX_WAIT-th unanswered cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RESET;
         pc        <= RESET_PC;
         ir        <= '0;
         wait_cnt  <= '0;
         fetch_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH) begin
            if (imem_ack) begin
               ir       <= imem_rdata;
               wait_cnt <= '0;
            end else begin
               if (wait_cnt != WCW'(MAX_WAIT)) wait_cnt <= wait_cnt + WCW'(1);
               if (wait_cnt >= WCW'(MAX_WAIT - 1)) fetch_err <= 1'b1;
            end
         end
         if (state == S_EXEC && !stall) pc <= next_pc;
      end
   end

   assign imem_addr = pc;
   assign op        = ir[31:26];
   assign rs        = ir[25:21];
   assign rt        = ir[20:16];
   assign rd        = ir[15:11];
   assign imm       = ir[15:0];
   assign funct     = ir[5:0];

endmodule
